// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard scheduler.
// Holds the scoreboard entry layout, forward-select codes and mult/div defaults.
package hazard_pkg;

    typedef struct packed {
        logic [4:0] addr;
        logic [1:0] tnew;
    } stage_t;

    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_sel_e;

    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    // One pipeline step older: result is one cycle closer, never below zero.
    function automatic stage_t stage_age(input stage_t s);
        stage_t r;
        r = s;
        if (s.tnew != 2'd0) begin
            r.tnew = s.tnew - 2'd1;
        end
        return r;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hazard_scheduler_if.sv
// ID-stage side of the hazard scheduler: operand/destination info in, stall and selects out.
// The master is the ID stage, the slave is the scheduler.
interface hazard_scheduler_if;
    import hazard_pkg::*;

    logic       id_valid;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_rs_used;
    logic       id_rt_used;
    logic [1:0] id_rs_tuse;
    logic [1:0] id_rt_tuse;
    logic [4:0] id_wr_addr;
    logic [1:0] id_tnew;
    logic       id_md_start;
    logic       id_md_div;
    logic       id_md_use;

    logic       stall;
    fwd_sel_e   fwd_rs_sel;
    fwd_sel_e   fwd_rt_sel;
    logic       md_start;
    logic       md_busy;

    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               id_rs_tuse, id_rt_tuse, id_wr_addr, id_tnew,
               id_md_start, id_md_div, id_md_use,
        input  stall, fwd_rs_sel, fwd_rt_sel, md_start, md_busy
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               id_rs_tuse, id_rt_tuse, id_wr_addr, id_tnew,
               id_md_start, id_md_div, id_md_use,
        output stall, fwd_rs_sel, fwd_rt_sel, md_start, md_busy
    );

endinterface

// File: rtl/hazard_match.sv
// Per-operand hazard check against the E/M/W scoreboard.
// Nearest matching stage wins; stall when its result is later than the operand's use.
module hazard_match
    import hazard_pkg::*;
(
    input  logic [4:0] addr_i,
    input  logic       used_i,
    input  logic [1:0] tuse_i,
    input  stage_t     e_i,
    input  stage_t     m_i,
    input  stage_t     w_i,
    output logic       stall_o,
    output fwd_sel_e   fwd_sel_o
);

    logic       hit;
    logic [1:0] hit_tnew;
    fwd_sel_e   hit_sel;

    always_comb begin
        hit      = 1'b0;
        hit_tnew = 2'd0;
        hit_sel  = FWD_GRF;
        if (used_i && (addr_i != 5'd0)) begin
            if (e_i.addr == addr_i) begin
                hit      = 1'b1;
                hit_tnew = e_i.tnew;
                hit_sel  = FWD_E;
            end else if (m_i.addr == addr_i) begin
                hit      = 1'b1;
                hit_tnew = m_i.tnew;
                hit_sel  = FWD_M;
            end else if (w_i.addr == addr_i) begin
                hit      = 1'b1;
                hit_tnew = w_i.tnew;
                hit_sel  = FWD_W;
            end
        end
    end

    assign stall_o = hit && (hit_tnew > tuse_i);

    // A match whose value is not ready yet forwards nothing here; a later stage picks it up.
    assign fwd_sel_o = (hit && (hit_tnew == 2'd0)) ? hit_sel : FWD_GRF;

endmodule

// File: rtl/hazard_scheduler.sv
// Tnew/Tuse hazard scheduler beside ID: scoreboard, stall, forward selects, mult/div interlock.
// Define HAZARD_MD_EN to build the mult/div busy counter; otherwise md_* outputs tie to 0.
module hazard_scheduler
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_scheduler_if.slave hz
);

    stage_t   sb_e_q, sb_e_d;
    stage_t   sb_m_q, sb_m_d;
    stage_t   sb_w_q, sb_w_d;
    logic     rs_stall, rt_stall, md_stall, stall;
    fwd_sel_e rs_sel, rt_sel;

    hazard_match u_match_rs (
        .addr_i    (hz.id_rs_addr),
        .used_i    (hz.id_rs_used),
        .tuse_i    (hz.id_rs_tuse),
        .e_i       (sb_e_q),
        .m_i       (sb_m_q),
        .w_i       (sb_w_q),
        .stall_o   (rs_stall),
        .fwd_sel_o (rs_sel)
    );

    hazard_match u_match_rt (
        .addr_i    (hz.id_rt_addr),
        .used_i    (hz.id_rt_used),
        .tuse_i    (hz.id_rt_tuse),
        .e_i       (sb_e_q),
        .m_i       (sb_m_q),
        .w_i       (sb_w_q),
        .stall_o   (rt_stall),
        .fwd_sel_o (rt_sel)
    );

    assign stall = hz.id_valid & (rs_stall | rt_stall | md_stall);

    // A stalled or empty ID slot enters E as a bubble; older entries advance regardless.
    always_comb begin
        sb_e_d = '0;
        if (hz.id_valid && !stall) begin
            sb_e_d.addr = hz.id_wr_addr;
            sb_e_d.tnew = hz.id_tnew;
        end
        sb_m_d = stage_age(sb_e_q);
        sb_w_d = stage_age(sb_m_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_e_q <= '0;
            sb_m_q <= '0;
            sb_w_q <= '0;
        end else begin
            sb_e_q <= sb_e_d;
            sb_m_q <= sb_m_d;
            sb_w_q <= sb_w_d;
        end
    end

    assign hz.stall      = stall;
    assign hz.fwd_rs_sel = rs_sel;
    assign hz.fwd_rt_sel = rt_sel;

`ifdef HAZARD_MD_EN
    localparam int unsigned CNT_W = cnt_width(MULT_CYC, DIV_CYC);

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_busy, md_start;

    assign md_busy  = (md_cnt_q != '0);
    assign md_stall = md_busy & (hz.id_md_start | hz.id_md_use);
    assign md_start = hz.id_valid & hz.id_md_start & ~stall;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start) begin
            md_cnt_d = hz.id_md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign hz.md_busy  = md_busy;
    assign hz.md_start = md_start;
`else
    logic unused_md;

    assign md_stall    = 1'b0;
    assign hz.md_busy  = 1'b0;
    assign hz.md_start = 1'b0;
    assign unused_md   = ^{hz.id_md_start, hz.id_md_div, hz.id_md_use,
                           MULT_CYC[0], DIV_CYC[0]};
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed pipeline scenarios plus random traffic
// compared against an in-flight-instruction reference model.
module tb_hazard_scheduler;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef HAZARD_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   md_end = -1;

    typedef struct {
        logic [4:0] addr;
        int         tnew0;
        int         enter;
    } inflight_t;
    inflight_t q[$];

    hazard_scheduler_if hif ();

    hazard_scheduler #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic drive(input bit v, input int rs, input bit rsu, input int rsut,
                         input int rt, input bit rtu, input int rtut,
                         input int wr, input int tn,
                         input bit mds, input bit mdd, input bit mdu);
        hif.id_valid    = v;
        hif.id_rs_addr  = 5'(rs);
        hif.id_rs_used  = rsu;
        hif.id_rs_tuse  = 2'(rsut);
        hif.id_rt_addr  = 5'(rt);
        hif.id_rt_used  = rtu;
        hif.id_rt_tuse  = 2'(rtut);
        hif.id_wr_addr  = 5'(wr);
        hif.id_tnew     = 2'(tn);
        hif.id_md_start = mds;
        hif.id_md_div   = mdd;
        hif.id_md_use   = mdu;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Youngest in-flight producer (at most 2 cycles past entering E) of this register decides.
    function automatic void ref_operand(input logic [4:0] a, input bit used, input int tuse,
                                        output bit st, output int sel);
        int age, rem;
        st  = 1'b0;
        sel = 0;
        if (!used || a == 5'd0) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            age = cyc - q[i].enter;
            if (age < 0 || age > 2) continue;
            if (q[i].addr == a) begin
                rem = (q[i].tnew0 > age) ? q[i].tnew0 - age : 0;
                st  = (rem > tuse);
                sel = (rem == 0) ? age + 1 : 0;
                return;
            end
        end
    endfunction

    // Checks the current ID cycle against the model, commits it, then steps one clock.
    task automatic cycle();
        bit rs_st, rt_st, busy, mdst, exp_stall, exp_start;
        int rs_sel, rt_sel;
        #1;
        while (q.size() > 0 && (cyc - q[0].enter) > 2) void'(q.pop_front());
        ref_operand(hif.id_rs_addr, hif.id_rs_used, int'(hif.id_rs_tuse), rs_st, rs_sel);
        ref_operand(hif.id_rt_addr, hif.id_rt_used, int'(hif.id_rt_tuse), rt_st, rt_sel);
        busy      = MD_EN && (cyc <= md_end);
        mdst      = busy && (hif.id_md_start || hif.id_md_use);
        exp_stall = hif.id_valid && (rs_st || rt_st || mdst);
        exp_start = MD_EN && hif.id_valid && hif.id_md_start && !exp_stall;
        chk("stall",      32'(hif.stall),      32'(exp_stall));
        chk("fwd_rs_sel", 32'(hif.fwd_rs_sel), 32'(rs_sel));
        chk("fwd_rt_sel", 32'(hif.fwd_rt_sel), 32'(rt_sel));
        chk("md_busy",    32'(hif.md_busy),    32'(busy));
        chk("md_start",   32'(hif.md_start),   32'(exp_start));
        if (hif.id_valid && !exp_stall)
            q.push_back('{addr: hif.id_wr_addr, tnew0: int'(hif.id_tnew), enter: cyc + 1});
        if (exp_start) md_end = cyc + (hif.id_md_div ? DIV_N : MULT_N);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        nop();
        repeat (3) cycle();
    endtask

    initial begin
        nop();
        #2;
        chk("rst_stall",    32'(hif.stall),      32'd0);
        chk("rst_fwd_rs",   32'(hif.fwd_rs_sel), 32'd0);
        chk("rst_fwd_rt",   32'(hif.fwd_rt_sel), 32'd0);
        chk("rst_md_start", 32'(hif.md_start),   32'd0);
        chk("rst_md_busy",  32'(hif.md_busy),    32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // lw $2 then addu reading $2 (tuse 1): one bubble, value not ID-forwardable yet
        drive(1, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0); cycle();
        drive(1, 2, 1, 1, 0, 0, 0, 8, 1, 0, 0, 0);
        #1 chk("lu_stall1", 32'(hif.stall), 32'd1); cycle();
        #1 chk("lu_stall0", 32'(hif.stall), 32'd0);
        chk("lu_fwd", 32'(hif.fwd_rs_sel), 32'd0); cycle();
        flush();

        // lw $6 then beq on $6 (tuse 0): two bubbles, then forward from W
        drive(1, 0, 0, 0, 0, 0, 0, 6, 2, 0, 0, 0); cycle();
        drive(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("lb_stall1", 32'(hif.stall), 32'd1); cycle();
        #1 chk("lb_stall2", 32'(hif.stall), 32'd1); cycle();
        #1 chk("lb_fwd_w", 32'(hif.fwd_rs_sel), 32'd3);
        chk("lb_stall0", 32'(hif.stall), 32'd0); cycle();
        flush();

        // lw $3 then sw with rt=$3 (tuse 2)
        drive(1, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0, 0); cycle();
        drive(1, 0, 0, 0, 3, 1, 2, 0, 0, 0, 0, 0);
        #1 chk("st_stall", 32'(hif.stall), 32'd0);
        chk("st_fwd", 32'(hif.fwd_rt_sel), 32'd0); cycle();
        flush();

        // addu $4 then beq on $4
        drive(1, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0); cycle();
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("ab_stall1", 32'(hif.stall), 32'd1); cycle();
        #1 chk("ab_fwd_m", 32'(hif.fwd_rs_sel), 32'd2);
        chk("ab_stall0", 32'(hif.stall), 32'd0); cycle();
        flush();

        // producer of $0 never interlocks
        drive(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0); cycle();
        drive(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("z_stall", 32'(hif.stall), 32'd0);
        chk("z_fwd_rs", 32'(hif.fwd_rs_sel), 32'd0);
        chk("z_fwd_rt", 32'(hif.fwd_rt_sel), 32'd0); cycle();
        flush();

        // jal (tnew 0) forwards straight from E
        drive(1, 0, 0, 0, 0, 0, 0, 31, 0, 0, 0, 0); cycle();
        drive(1, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("lk_fwd_e", 32'(hif.fwd_rs_sel), 32'd1);
        chk("lk_stall", 32'(hif.stall), 32'd0); cycle();
        flush();

        // both operands on the same entry: rt (tuse 0) alone forces the stall
        drive(1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0); cycle();
        drive(1, 7, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        #1 chk("bo_stall", 32'(hif.stall), 32'd1); cycle();
        cycle();
        flush();

`ifdef HAZARD_MD_EN
        // mult then mfhi: busy 5 cycles, mfhi waits out all of them
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        #1 chk("md_mult_start", 32'(hif.md_start), 32'd1); cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 1);
        for (int i = 0; i < MULT_N; i++) begin
            #1 chk("md_mf_stall", 32'(hif.stall), 32'd1);
            chk("md_mf_busy", 32'(hif.md_busy), 32'd1); cycle();
        end
        #1 chk("md_mf_go", 32'(hif.stall), 32'd0);
        chk("md_mf_idle", 32'(hif.md_busy), 32'd0); cycle();
        flush();

        // div requested in the last busy cycle stalls once, then issues
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle();
        nop();
        repeat (MULT_N - 1) cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        #1 chk("md_div_wait", 32'(hif.stall), 32'd1);
        chk("md_div_nostart", 32'(hif.md_start), 32'd0); cycle();
        #1 chk("md_div_start", 32'(hif.md_start), 32'd1); cycle();
        nop();
        repeat (DIV_N + 1) cycle();
`endif

        // async reset during a load stall with the mult/div counter at 7
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); cycle();
        nop(); cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 5, 2, 0, 0, 0); cycle();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        #1 chk("ar_pre_stall", 32'(hif.stall), 32'd1);
`ifdef HAZARD_MD_EN
        chk("ar_pre_busy", 32'(hif.md_busy), 32'd1);
`endif
        rst_n = 1'b0;
        #1 chk("ar_stall", 32'(hif.stall), 32'd0);
        chk("ar_busy", 32'(hif.md_busy), 32'd0);
        chk("ar_fwd", 32'(hif.fwd_rs_sel), 32'd0);
        nop();
        q.delete();
        md_end = -1;
        cyc += 10;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
        flush();

        // random traffic on a small register set to provoke frequent hazards
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) != 0),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2),
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                  ($urandom_range(0, 5) == 0));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
